// File: rtl/msg_pkg.sv
// Shared definitions for the message sender and its neighbours.
// Holds the message ID constants, field widths of the string ROM and the
// sequencer state encoding.
package msg_pkg;

  localparam int ID_W    = 2;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 5;
  localparam int STR_W   = MAX_LEN * 8;

  localparam logic [ID_W-1:0] MSG_START = 2'd0;
  localparam logic [ID_W-1:0] MSG_SHELL = 2'd1;
  localparam logic [ID_W-1:0] MSG_ERROR = 2'd2;
  localparam logic [ID_W-1:0] MSG_PONG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/msg_sender.sv
// msg_sender: fetches a packed string from the string ROM for a requested
// message ID and streams it byte by byte into the UART transmitter.
//
// Ports:
//   clk, rst            system clock (rising edge), async active-high reset
//   req_valid/req_id    message request from the shell/command side
//   req_ready           high while idle, request accepted on valid&ready
//   rom_id              ID presented to the combinational string ROM
//   rom_string          packed string, last character at [7:0]
//   rom_length          number of characters in rom_string
//   tx_data/tx_valid    byte stream to uart_tx, transfer on valid&ready
//   tx_ready            uart_tx accepts the current byte
//   done                one-cycle pulse once the whole message is handed off
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// LOAD  | ROM output for the latched ID captured, byte index preset
// SEND  | presenting byte idx, decrement on every transfer
// DONE  | one-cycle completion pulse, back to IDLE
module msg_sender
  import msg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  output logic [ID_W-1:0]  rom_id,
  input  logic [STR_W-1:0] rom_string,
  input  logic [LEN_W-1:0] rom_length,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             done
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rom_id_q, rom_id_d;
  logic [STR_W-1:0]   str_q, str_d;
  logic [LEN_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rom_id_q <= '0;
      str_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rom_id_q <= rom_id_d;
      str_q    <= str_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rom_id_d  = rom_id_q;
    str_d     = str_q;
    idx_d     = idx_q;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rom_id_d = req_id;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        str_d = rom_string;
        if (rom_length == '0) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          // first character out is the highest populated byte
          idx_d   = rom_length - 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        // output is a pure function of latched registers, so it cannot
        // change while uart_tx stalls
        tx_data  = str_q[{idx_q, 3'b000} +: 8];
        if (tx_ready) begin
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_id = rom_id_q;

endmodule

// File: tb/tb_msg_sender.sv
module tb_msg_sender;
  import msg_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [ID_W-1:0]  req_id;
  logic             req_ready;
  logic [ID_W-1:0]  rom_id;
  logic [STR_W-1:0] rom_string;
  logic [LEN_W-1:0] rom_length;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             done;

  msg_sender dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_ready  (req_ready),
    .rom_id     (rom_id),
    .rom_string (rom_string),
    .rom_length (rom_length),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // string ROM stub
  bit rom_zero    = 1'b0;
  bit rom_corrupt = 1'b0;

  function automatic logic [STR_W-1:0] rom_str(input logic [ID_W-1:0] id);
    logic [STR_W-1:0] s;
    s = '0;
    case (id)
      MSG_START: s[119:0] = "starting up...\n";
      MSG_SHELL: s[23:0]  = {8'h0A, "$>"};
      MSG_ERROR: s[175:0] = "error: invalid command";
      default:   s[31:0]  = "PONG";
    endcase
    return s;
  endfunction

  function automatic int rom_len(input logic [ID_W-1:0] id);
    case (id)
      MSG_START: return 15;
      MSG_SHELL: return 3;
      MSG_ERROR: return 22;
      default:   return 4;
    endcase
  endfunction

  always_comb begin
    rom_string = rom_str(rom_id);
    rom_length = LEN_W'(rom_len(rom_id));
    if (rom_zero) rom_length = '0;
    if (rom_corrupt) begin
      rom_string = {32{8'h5A}};
      rom_length = 5'd9;
    end
  end

  // scoreboard / tracking
  int         n_checks = 0;
  int         n_fails  = 0;
  int         cyc      = 0;
  bit         ready_toggle = 1'b0;
  logic [7:0] exp_q[$];
  int         xfer_cnt, done_cnt, accept_cyc, last_xfer_cyc, cur_len;
  bit         first_pending = 1'b0;
  bit         s_req_ready;
  int         s_cyc;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    s_req_ready = req_ready;
    s_cyc       = cyc;
    if (rst) begin
      prev_valid = 1'b0;
      return;
    end
    if (prev_valid && !prev_ready) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(prev_data));
    end
    if (tx_valid) begin
      check("busy_req_ready", 32'(req_ready), 32'd0);
      if (first_pending) begin
        check("first_latency", cyc, accept_cyc + 2);
        first_pending = 1'b0;
      end
      if (tx_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (done) begin
      done_cnt++;
      check("done_queue_empty", exp_q.size(), 0);
      check("done_req_ready", 32'(req_ready), 32'd0);
      check("done_tx_valid", 32'(tx_valid), 32'd0);
      if (cur_len == 0) check("done_latency_zero", cyc, accept_cyc + 2);
      else              check("done_latency", cyc, last_xfer_cyc + 1);
    end
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    if (ready_toggle) tx_ready = ~tx_ready;
    else              tx_ready = 1'b1;
  endtask

  task automatic send_req(input logic [ID_W-1:0] id, input bit zero);
    logic [STR_W-1:0] s;
    int n;
    rom_zero  = zero;
    req_id    = id;
    req_valid = 1'b1;
    xfer_cnt  = 0;
    done_cnt  = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_req_ready && n < 100);
    req_valid = 1'b0;
    check("accept", 32'(s_req_ready), 32'd1);
    accept_cyc    = s_cyc;
    cur_len       = zero ? 0 : rom_len(id);
    first_pending = (cur_len != 0);
    s = rom_str(id);
    for (int i = cur_len - 1; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    check("rom_id", 32'(rom_id), 32'(id));
  endtask

  task automatic wait_done(input int budget, input int extra);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
    for (int i = 0; i < extra; i++) tick();
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    bit              toggle;
    bit              zero;
    int              exp_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int first_acc;
    int n;

    vecs[0] = '{MSG_PONG,  1'b0, 1'b0, 4};
    vecs[1] = '{MSG_SHELL, 1'b1, 1'b0, 3};
    vecs[2] = '{MSG_START, 1'b0, 1'b0, 15};
    vecs[3] = '{MSG_PONG,  1'b0, 1'b1, 0};
    vecs[4] = '{MSG_ERROR, 1'b1, 1'b0, 22};
    vecs[5] = '{MSG_SHELL, 1'b0, 1'b1, 0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_id    = MSG_ERROR;
    tx_ready  = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rom_id", 32'(rom_id), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // table-driven messages
    for (int v = 0; v < 6; v++) begin
      ready_toggle = vecs[v].toggle;
      send_req(vecs[v].id, vecs[v].zero);
      wait_done(200, 2);
      check("xfer_count", xfer_cnt, vecs[v].exp_len);
      check("done_count", done_cnt, 1);
    end
    rom_zero = 1'b0;

    // request held while busy is only taken once back in IDLE
    ready_toggle = 1'b0;
    send_req(MSG_ERROR, 1'b0);
    first_acc = accept_cyc;
    for (int i = 0; i < 5; i++) tick();
    req_id    = MSG_PONG;
    req_valid = 1'b1;
    wait_done(200, 0);
    check("held_xfer_count", xfer_cnt, 22);
    check("held_done_count", done_cnt, 1);
    send_req(MSG_PONG, 1'b0);
    check("req_spacing", accept_cyc - first_acc, 22 + 3);
    wait_done(100, 2);
    check("pong_xfer_count", xfer_cnt, 4);

    // reset in the middle of a message
    send_req(MSG_START, 1'b0);
    n = 0;
    while (xfer_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rom_id", 32'(rom_id), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    first_pending = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_done", done_cnt, 0);
    send_req(MSG_START, 1'b0);
    wait_done(100, 2);
    check("restart_xfer_count", xfer_cnt, 15);
    check("restart_done_count", done_cnt, 1);

    // ROM and req_id disturbed while a message is in flight
    ready_toggle = 1'b1;
    send_req(MSG_START, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    req_id      = MSG_ERROR;
    rom_corrupt = 1'b1;
    wait_done(200, 0);
    rom_corrupt = 1'b0;
    check("frozen_rom_id", 32'(rom_id), 32'(MSG_START));
    tick();
    tick();
    check("frozen_xfer_count", xfer_cnt, 15);
    check("frozen_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
